// File: rtl/mult_share_arb.sv
// mult_share_arb: two requesters time-share one combinational multiplier.
// Round-robin grant, registered operands, product held until the consumer accepts it.

module nBitMultiplier #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] p
);
  assign p = {{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, q};
endmodule

module mult_share_arb #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_m,
  input  logic [WIDTH-1:0]   req0_q,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_m,
  input  logic [WIDTH-1:0]   req1_q,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_p,
  output logic               res_id,
  output logic               busy,
  output logic [CNT_W-1:0]   ops_done
);
  // state | meaning
  // IDLE  | waiting for a request; grant and ready are live
  // CALC  | operands registered, multiplier output settling
  // DONE  | product held on res_p until res_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT state, stateNext;

  logic               grant;
  logic               lastGrant;
  logic               anyValid;
  logic [WIDTH-1:0]   opM;
  logic [WIDTH-1:0]   opQ;
  logic               opId;
  logic [2*WIDTH-1:0] product;

  nBitMultiplier #(.WIDTH(WIDTH)) uMult (
    .m (opM),
    .q (opQ),
    .p (product)
  );

  assign anyValid = req0_valid | req1_valid;
  assign busy     = (state != IDLE);

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~lastGrant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (anyValid) begin
          req0_ready = req0_valid & ~grant;
          req1_ready = req1_valid & grant;
          stateNext  = CALC;
        end
      end
      CALC:    stateNext = DONE;
      DONE:    if (res_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opM       <= '0;
      opQ       <= '0;
      opId      <= 1'b0;
      lastGrant <= 1'b1;
      res_p     <= '0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      ops_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyValid) begin
            opM       <= grant ? req1_m : req0_m;
            opQ       <= grant ? req1_q : req0_q;
            opId      <= grant;
            lastGrant <= grant;
          end
        end
        CALC: begin
          res_p     <= product;
          res_id    <= opId;
          res_valid <= 1'b1;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
